tmp3_responder: RTL and testbench
=================================

Name: tmp3_responder

Overview:
- I2C target (responder) that behaves as a Pmod TMP3 sensor: address 1001_A2A1A0, a 2-bit pointer, and ambient, config, hysteresis and limit registers.
- Provides the other end of the TMP3 host interface, for loopback testing of the host on the board and for sensor emulation on a Pmod header.
- Samples SCL/SDA with the system clock. Never drives SCL (no clock stretching).

Parameters:
- HYST_RST, 9'h096, reset value of the hysteresis register (75.0 C, 0.5 C LSB).
- LIMIT_RST, 9'h0A0, reset value of the limit register (80.0 C).

Ports:
- clk  input  1  system clock; must be at least 16x SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- SCL_i  input  1  I2C clock from the pad.
- SDA_i  input  1  I2C data from the pad.
- SDA_o  output  1  constant 0 (open-drain emulation).
- SDA_t  output  1  1 = release SDA; 0 = pull SDA low.
- address_bits  input  3  A2..A0 of the target address.
- temperature_i  input  12  ambient temperature, two's complement, 0.0625 C LSB.
- sample  input  1  one-clk pulse: a new temperature_i is valid.
- config_o  output  8  config register: {0, resolution[1:0], fault_queue[1:0], alert_polarity, interrupt_mode, shutdown}.
- hyst_o  output  9  hysteresis register.
- limit_o  output  9  limit register.
- pointer_o  output  2  current pointer.
- busy  output  1  high while this target is addressed (address ACK until STOP or repeated START).
- reg_write  output  1  one-clk pulse when a register commit happens.
- alert  output  1  ALERT pin level (see Optional Feature).

Behaviour:
- Input path: SCL_i and SDA_i pass through a 2-FF synchronizer plus one delay stage. Edges and conditions are detected on the synchronized signals.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Reset values:
  - SDA_t=1, busy=0, reg_write=0, alert=inactive level (1 when polarity 0 — see below), pointer=0, config=8'h00.
  - hyst=HYST_RST, limit=LIMIT_RST, temperature snapshot=0.
- Temperature snapshot: on `sample` with config[0]=0, store temperature_i masked to the resolution. Resolution 00/01/10/11 keeps 9/10/11/12 MSBs; the remaining LSBs are zeroed. While config[0]=1 (shutdown), the snapshot holds.
- Read image (16-bit view of the snapshot): MSB byte = snap[11:4]; LSB byte = {snap[3:0], 4'b0}.
- FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE.
  - START from any state -> ADDR, with the bit counter cleared.
  - STOP from any state -> IDLE, SDA_t=1, busy=0.
  - ADDR: shift 8 bits on SCL rising edges.
    - If the top 7 bits = {1001, address_bits} -> ADDR_ACK.
    - Otherwise -> IGNORE (no drive until START/STOP).
  - ADDR_ACK: pull SDA low from the SCL falling edge after bit 8 until the next SCL falling edge. Then go to TX_BYTE if R/W=1, else RX_BYTE.
  - The byte index resets to 0 at every address match.
  - RX_BYTE, write direction:
    - Byte 0 sets pointer = data[1:0]; data[7:2] is ignored.
    - Config register: byte 1 commits config.
    - Hyst/limit registers: byte 1 is held temporarily; byte 2 commits reg = {byte1, byte2[7]}.
    - A STOP after only byte 1 discards it.
    - Writes to pointer 00 are ignored.
    - Extra bytes are ACKed and ignored.
    - Every byte is ACKed in RX_ACK.
    - reg_write pulses one clk at the commit.
  - TX_BYTE: drive the MSB-first bit on each SCL falling edge.
    - SDA_t = bit value: 0 drives low, 1 releases.
    - Data source:
      - 2-byte registers alternate MSB, LSB, MSB...
      - Config repeats every byte.
      - Hyst/limit LSB = {reg[0], 7'b0}.
    - The ambient image is latched at ADDR_ACK, so one transaction is never torn by a `sample`.
  - TX_ACK: release SDA and sample SDA on the SCL rising edge.
    - ACK (0) -> TX_BYTE, next byte.
    - NACK (1) -> IGNORE.
- SDA changes only while SCL is low, at most 4 clk after the synchronized SCL falling edge.
- Repeated START keeps the pointer.
- Reset mid-transaction releases SDA immediately.

Optional Feature:
- Macro: TMP3_RESP_ALERT_EN.
- Defined: alert logic is evaluated on each `sample` while not in shutdown, using the 9-bit temperature t = snap[11:3].
  - Fault counter threshold: 1/2/4/6 consecutive out-of-range samples for fault_queue 00/01/10/11.
  - Comparator mode (config[1]=0): assert when t >= limit for the threshold count; deassert when t < hyst for the threshold count.
  - Interrupt mode (config[1]=1): assert on the same trip condition; cleared by any completed read transaction (address ACK with R/W=1).
  - Output: pin = active XOR ~config[2]. Polarity 1 means active-high.
- Not defined: alert tied to 1 (inactive, active-low default); fault logic absent.

Test Plan:
- Write 0x90, 0x01, 0x60, STOP with address_bits=000 -> ACK on all 3 bytes, config_o=8'h60, one reg_write pulse, pointer_o=01.
- temperature_i=12'h195 with sample, resolution 11, then write pointer 00 and read 2 bytes (ACK, NACK) -> bytes 0x19, 0x50. The same sequence at resolution 00 -> 0x19, 0x00.
- Write pointer 11 with 0x20, 0x80 -> limit_o=9'h041. Write pointer 10 with 0x10 only, then STOP -> hyst_o stays 9'h096.
- Address 0x92 while address_bits=000 -> SDA_t stays 1 through the whole transaction, busy=0, no reg_write.
- Read pointer 01 for 3 bytes -> config byte returned 3 times. Master NACK then releases SDA; a following repeated START plus read works.
- With TMP3_RESP_ALERT_EN defined, fault_queue=01, polarity 0: two samples at t >= limit -> alert falls to 0; two samples below hyst -> alert returns to 1.

Source files
------------

// File: rtl/tmp3_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmp3_responder_if : I2C pad bundle for the TMP3 responder            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface tmp3_responder_if;
  logic SCL_i;
  logic SDA_i;
  logic SDA_o;
  logic SDA_t;

  modport master (output SCL_i, output SDA_i, input SDA_o, input SDA_t);
  modport slave  (input SCL_i, input SDA_i, output SDA_o, output SDA_t);
endinterface
`default_nettype wire

// File: rtl/tmp3_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmp3_responder : I2C target emulating a Pmod TMP3 temperature sensor |
// | Optional ALERT fault logic enabled by macro TMP3_RESP_ALERT_EN       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tmp3_responder #(
  parameter logic [8:0] HYST_RST  = 9'h096,
  parameter logic [8:0] LIMIT_RST = 9'h0A0
) (
  input  logic                    clk,
  input  logic                    rst,
  tmp3_responder_if.slave         bus,
  input  logic [2:0]              address_bits,
  input  logic [11:0]             temperature_i,
  input  logic                    sample,
  output logic [7:0]              config_o,
  output logic [8:0]              hyst_o,
  output logic [8:0]              limit_o,
  output logic [1:0]              pointer_o,
  output logic                    busy,
  output logic                    reg_write,
  output logic                    alert
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_RX_BYTE  = 3'd3,
    S_RX_ACK   = 3'd4,
    S_TX_BYTE  = 3'd5,
    S_TX_ACK   = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  state_t      r_state, w_state_nx;
  logic [2:0]  r_scl_q, r_sda_q;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic [7:0]  r_shift, w_shift_nx;
  logic        r_sda_t, w_sda_t_nx;
  logic [1:0]  r_idx, w_idx_nx;
  logic        r_busy, w_busy_nx;
  logic        r_rw, w_rw_nx;
  logic        w_match, w_rx_done;
  logic [1:0]  r_pointer;
  logic [7:0]  r_config, r_hold;
  logic [8:0]  r_hyst, r_limit;
  logic [11:0] r_snap, r_img, w_mask, w_new_snap;
  logic        r_reg_write;
  logic [7:0]  w_tx_byte;

  // Two sync stages plus one delay stage so edges are seen on clean signals
  wire w_scl      = r_scl_q[1];
  wire w_sda      = r_sda_q[1];
  wire w_scl_rise = r_scl_q[1] & ~r_scl_q[2];
  wire w_scl_fall = ~r_scl_q[1] & r_scl_q[2];
  wire w_start    = w_scl & r_scl_q[2] & ~r_sda_q[1] & r_sda_q[2];
  wire w_stop     = w_scl & r_scl_q[2] & r_sda_q[1] & ~r_sda_q[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_q <= 3'b111;
      r_sda_q <= 3'b111;
    end else begin
      r_scl_q <= {r_scl_q[1:0], bus.SCL_i};
      r_sda_q <= {r_sda_q[1:0], bus.SDA_i};
    end
  end

  always_comb begin
    w_mask = 12'hFFF;
    case (r_config[6:5])
      2'b00:   w_mask = 12'hFF8;
      2'b01:   w_mask = 12'hFFC;
      2'b10:   w_mask = 12'hFFE;
      default: w_mask = 12'hFFF;
    endcase
    w_new_snap = temperature_i & w_mask;
  end

  always_comb begin
    w_tx_byte = r_config;
    case (r_pointer)
      2'b00:   w_tx_byte = r_idx[0] ? {r_img[3:0], 4'b0000} : r_img[11:4];
      2'b01:   w_tx_byte = r_config;
      2'b10:   w_tx_byte = r_idx[0] ? {r_hyst[0], 7'b0}  : r_hyst[8:1];
      default: w_tx_byte = r_idx[0] ? {r_limit[0], 7'b0} : r_limit[8:1];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_shift <= 8'h00;
      r_sda_t <= 1'b1;
      r_idx   <= 2'd0;
      r_busy  <= 1'b0;
      r_rw    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_shift <= w_shift_nx;
      r_sda_t <= w_sda_t_nx;
      r_idx   <= w_idx_nx;
      r_busy  <= w_busy_nx;
      r_rw    <= w_rw_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_sda_t_nx = r_sda_t;
    w_idx_nx   = r_idx;
    w_busy_nx  = r_busy;
    w_rw_nx    = r_rw;
    w_match    = 1'b0;
    w_rx_done  = 1'b0;
    if (w_stop) begin
      w_state_nx = S_IDLE;
      w_sda_t_nx = 1'b1;
      w_busy_nx  = 1'b0;
    end else if (w_start) begin
      w_state_nx = S_ADDR;
      w_cnt_nx   = 4'd0;
      w_sda_t_nx = 1'b1;
      w_busy_nx  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nx = {r_shift[6:0], w_sda};
            w_cnt_nx   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            if (r_shift[7:1] == {4'b1001, address_bits}) begin
              w_state_nx = S_ADDR_ACK;
              w_sda_t_nx = 1'b0;
              w_busy_nx  = 1'b1;
              w_rw_nx    = r_shift[0];
              w_idx_nx   = 2'd0;
              w_match    = 1'b1;
            end else begin
              w_state_nx = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nx = 4'd0;
            if (r_rw) begin
              w_state_nx = S_TX_BYTE;
              w_sda_t_nx = w_tx_byte[7];
            end else begin
              w_state_nx = S_RX_BYTE;
              w_sda_t_nx = 1'b1;
            end
          end
        end
        S_RX_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nx = {r_shift[6:0], w_sda};
            w_cnt_nx   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_state_nx = S_RX_ACK;
            w_sda_t_nx = 1'b0;
            w_rx_done  = 1'b1;
            w_idx_nx   = (r_idx == 2'd3) ? 2'd3 : r_idx + 2'd1;
          end
        end
        S_RX_ACK: begin
          if (w_scl_fall) begin
            w_state_nx = S_RX_BYTE;
            w_sda_t_nx = 1'b1;
            w_cnt_nx   = 4'd0;
          end
        end
        S_TX_BYTE: begin
          if (w_scl_rise) begin
            w_cnt_nx = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_state_nx = S_TX_ACK;
              w_sda_t_nx = 1'b1;
            end else begin
              w_sda_t_nx = w_tx_byte[3'd7 - r_cnt[2:0]];
            end
          end
        end
        S_TX_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_state_nx = S_IGNORE;
            end else begin
              w_state_nx = S_TX_BYTE;
              w_cnt_nx   = 4'd0;
              w_idx_nx   = r_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Hyst/limit take two data bytes; the first is parked in r_hold until the second lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pointer   <= 2'b00;
      r_config    <= 8'h00;
      r_hyst      <= HYST_RST;
      r_limit     <= LIMIT_RST;
      r_hold      <= 8'h00;
      r_snap      <= 12'h000;
      r_img       <= 12'h000;
      r_reg_write <= 1'b0;
    end else begin
      r_reg_write <= 1'b0;
      if (sample && !r_config[0])
        r_snap <= w_new_snap;
      if (w_match)
        r_img <= r_snap;
      if (w_rx_done) begin
        case (r_idx)
          2'd0: r_pointer <= r_shift[1:0];
          2'd1: begin
            if (r_pointer == 2'b01) begin
              r_config    <= {1'b0, r_shift[6:0]};
              r_reg_write <= 1'b1;
            end else if (r_pointer[1]) begin
              r_hold <= r_shift;
            end
          end
          2'd2: begin
            if (r_pointer == 2'b10) begin
              r_hyst      <= {r_hold, r_shift[7]};
              r_reg_write <= 1'b1;
            end else if (r_pointer == 2'b11) begin
              r_limit     <= {r_hold, r_shift[7]};
              r_reg_write <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TMP3_RESP_ALERT_EN
  logic       r_active;
  logic [2:0] r_fcnt, w_thr;
  logic       w_trip;
  wire [8:0]  w_t = w_new_snap[11:3];

  always_comb begin
    w_thr = 3'd1;
    case (r_config[4:3])
      2'b00:   w_thr = 3'd1;
      2'b01:   w_thr = 3'd2;
      2'b10:   w_thr = 3'd4;
      default: w_thr = 3'd6;
    endcase
    if (r_active)
      w_trip = !r_config[1] && ($signed(w_t) < $signed(r_hyst));
    else
      w_trip = $signed(w_t) >= $signed(r_limit);
  end

  // Interrupt-mode alerts are acknowledged by any read addressing this target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_fcnt   <= 3'd0;
    end else if (w_match && r_shift[0] && r_config[1]) begin
      r_active <= 1'b0;
      r_fcnt   <= 3'd0;
    end else if (sample && !r_config[0]) begin
      if (w_trip) begin
        if (r_fcnt + 3'd1 >= w_thr) begin
          r_active <= ~r_active;
          r_fcnt   <= 3'd0;
        end else begin
          r_fcnt <= r_fcnt + 3'd1;
        end
      end else begin
        r_fcnt <= 3'd0;
      end
    end
  end

  assign alert = r_active ^ ~r_config[2];
`else
  assign alert = 1'b1;
`endif

  assign bus.SDA_o = 1'b0;
  assign bus.SDA_t = r_sda_t;
  assign config_o  = r_config;
  assign hyst_o    = r_hyst;
  assign limit_o   = r_limit;
  assign pointer_o = r_pointer;
  assign busy      = r_busy;
  assign reg_write = r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_tmp3_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tmp3_responder : bit-banged I2C host driving the TMP3 responder   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_tmp3_responder;
  localparam int c_Q = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl, m_sda;
  logic [2:0]  address_bits;
  logic [11:0] temperature_i;
  logic        sample;
  logic [7:0]  config_o;
  logic [8:0]  hyst_o, limit_o;
  logic [1:0]  pointer_o;
  logic        busy, reg_write, alert;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int low_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] exp_q[$];

  tmp3_responder_if bus();
  assign bus.SCL_i = scl;
  assign bus.SDA_i = m_sda & bus.SDA_t;

  tmp3_responder dut (
    .clk(clk), .rst(rst), .bus(bus), .address_bits(address_bits),
    .temperature_i(temperature_i), .sample(sample), .config_o(config_o),
    .hyst_o(hyst_o), .limit_o(limit_o), .pointer_o(pointer_o),
    .busy(busy), .reg_write(reg_write), .alert(alert)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_write) wr_cnt <= wr_cnt + 1;
    if (!bus.SDA_t) low_cnt <= low_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic got(input string tag, input logic [7:0] v);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, v);
    end else begin
      check(tag, {8'h00, v}, {8'h00, exp_q.pop_front()});
    end
  endtask

  task automatic hw();
    repeat (c_Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; scl = 1'b1; hw();
    m_sda = 1'b0; hw();
    scl = 1'b0; hw();
  endtask

  task automatic i2c_rstart();
    m_sda = 1'b1; hw();
    scl = 1'b1; hw();
    m_sda = 1'b0; hw();
    scl = 1'b0; hw();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; hw();
    scl = 1'b1; hw();
    m_sda = 1'b1; hw();
  endtask

  task automatic wbit(input logic b);
    m_sda = b; hw();
    scl = 1'b1; hw(); hw();
    scl = 1'b0; hw();
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; hw();
    scl = 1'b1; hw();
    b = bus.SDA_i; hw();
    scl = 1'b0; hw();
  endtask

  task automatic wbyte(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    exp_q.push_back({7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(a);
    got(tag, {7'd0, a});
  endtask

  task automatic rbyte(input string tag, input logic [7:0] exp, input logic ack);
    logic [7:0] d;
    logic       b;
    exp_q.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(ack);
    got(tag, d);
  endtask

  task automatic pulse_sample(input logic [11:0] t);
    @(negedge clk);
    temperature_i = t;
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
  endtask

  int base_wr, base_low, base_busy;

  initial begin
    rst = 1'b0; scl = 1'b1; m_sda = 1'b1;
    address_bits = 3'b000; temperature_i = 12'h000; sample = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_sda_t",   {15'd0, bus.SDA_t}, 16'h0001);
    check("rst_busy",    {15'd0, busy},      16'h0000);
    check("rst_regwr",   {15'd0, reg_write}, 16'h0000);
    check("rst_alert",   {15'd0, alert},     16'h0001);
    check("rst_pointer", {14'd0, pointer_o}, 16'h0000);
    check("rst_config",  {8'd0, config_o},   16'h0000);
    check("rst_hyst",    {7'd0, hyst_o},     16'h0096);
    check("rst_limit",   {7'd0, limit_o},    16'h00A0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // config write: 0x90 0x01 0x60
    base_wr = wr_cnt;
    i2c_start();
    wbyte("cfg_addr_ack", 8'h90, 1'b0);
    check("cfg_busy", {15'd0, busy}, 16'h0001);
    wbyte("cfg_ptr_ack", 8'h01, 1'b0);
    wbyte("cfg_data_ack", 8'h60, 1'b0);
    i2c_stop();
    hw();
    check("cfg_value", {8'd0, config_o}, 16'h0060);
    check("cfg_regwr_cnt", 16'(wr_cnt - base_wr), 16'd1);
    check("cfg_pointer", {14'd0, pointer_o}, 16'h0001);
    check("cfg_busy_after_stop", {15'd0, busy}, 16'h0000);

    // ambient read at 12-bit resolution
    pulse_sample(12'h195);
    i2c_start();
    wbyte("amb12_addr", 8'h90, 1'b0);
    wbyte("amb12_ptr", 8'h00, 1'b0);
    i2c_rstart();
    wbyte("amb12_raddr", 8'h91, 1'b0);
    rbyte("amb12_msb", 8'h19, 1'b0);
    rbyte("amb12_lsb", 8'h50, 1'b1);
    i2c_stop();

    // ambient read at 9-bit resolution
    i2c_start();
    wbyte("res9_addr", 8'h90, 1'b0);
    wbyte("res9_ptr", 8'h01, 1'b0);
    wbyte("res9_data", 8'h00, 1'b0);
    i2c_stop();
    pulse_sample(12'h195);
    i2c_start();
    wbyte("amb9_addr", 8'h90, 1'b0);
    wbyte("amb9_ptr", 8'h00, 1'b0);
    i2c_rstart();
    wbyte("amb9_raddr", 8'h91, 1'b0);
    rbyte("amb9_msb", 8'h19, 1'b0);
    rbyte("amb9_lsb", 8'h00, 1'b1);
    i2c_stop();

    // limit full write, hyst partial write
    base_wr = wr_cnt;
    i2c_start();
    wbyte("lim_addr", 8'h90, 1'b0);
    wbyte("lim_ptr", 8'h03, 1'b0);
    wbyte("lim_b1", 8'h20, 1'b0);
    wbyte("lim_b2", 8'h80, 1'b0);
    i2c_stop();
    hw();
    check("limit_value", {7'd0, limit_o}, 16'h0041);
    i2c_start();
    wbyte("hyst_addr", 8'h90, 1'b0);
    wbyte("hyst_ptr", 8'h02, 1'b0);
    wbyte("hyst_b1", 8'h10, 1'b0);
    i2c_stop();
    hw();
    check("hyst_discard", {7'd0, hyst_o}, 16'h0096);
    check("limhyst_regwr_cnt", 16'(wr_cnt - base_wr), 16'd1);

    // pointer still 10: read hyst, then limit via repeated START
    i2c_start();
    wbyte("rdh_raddr", 8'h91, 1'b0);
    rbyte("rdh_msb", 8'h4B, 1'b0);
    rbyte("rdh_lsb", 8'h00, 1'b1);
    i2c_rstart();
    wbyte("rdl_addr", 8'h90, 1'b0);
    wbyte("rdl_ptr", 8'h03, 1'b0);
    i2c_rstart();
    wbyte("rdl_raddr", 8'h91, 1'b0);
    rbyte("rdl_msb", 8'h20, 1'b0);
    rbyte("rdl_lsb", 8'h80, 1'b1);
    i2c_stop();

    // foreign address must be ignored
    base_wr = wr_cnt; base_low = low_cnt; base_busy = busy_cnt;
    i2c_start();
    wbyte("foreign_addr_nack", 8'h92, 1'b1);
    wbyte("foreign_data_nack", 8'h01, 1'b1);
    wbyte("foreign_data2_nack", 8'h55, 1'b1);
    i2c_stop();
    hw();
    check("foreign_sda_low", 16'(low_cnt - base_low), 16'd0);
    check("foreign_busy", 16'(busy_cnt - base_busy), 16'd0);
    check("foreign_regwr", 16'(wr_cnt - base_wr), 16'd0);
    check("foreign_config", {8'd0, config_o}, 16'h0000);

    // config 0x68 repeated three times, then NACK and repeated START read
    i2c_start();
    wbyte("cfg3_addr", 8'h90, 1'b0);
    wbyte("cfg3_ptr", 8'h01, 1'b0);
    wbyte("cfg3_data", 8'h68, 1'b0);
    i2c_rstart();
    wbyte("cfg3_raddr", 8'h91, 1'b0);
    rbyte("cfg3_b0", 8'h68, 1'b0);
    rbyte("cfg3_b1", 8'h68, 1'b0);
    rbyte("cfg3_b2", 8'h68, 1'b1);
    check("nack_release", {15'd0, bus.SDA_t}, 16'h0001);
    i2c_rstart();
    wbyte("rs_raddr", 8'h91, 1'b0);
    rbyte("rs_b0", 8'h68, 1'b1);
    i2c_stop();
    hw();
    check("rs_pointer", {14'd0, pointer_o}, 16'h0001);

    // alert: fault queue 2, limit 0x041, hyst 0x096
    pulse_sample(12'h7F0);
    check("alert_one_high", {15'd0, alert}, 16'h0001);
    pulse_sample(12'h7F0);
`ifdef TMP3_RESP_ALERT_EN
    check("alert_two_high", {15'd0, alert}, 16'h0000);
    pulse_sample(12'h000);
    check("alert_one_low", {15'd0, alert}, 16'h0000);
    pulse_sample(12'h000);
    check("alert_two_low", {15'd0, alert}, 16'h0001);
`else
    check("alert_tied", {15'd0, alert}, 16'h0001);
`endif

    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
